// File: rtl/pm_loader_if.sv
// Host byte stream and program-memory write port of the boot loader.
// The slave modport is the loader side and the master modport is the host/memory side.
interface pm_loader_if #(
    parameter int PMA_SIZE = 16,
    parameter int PMD_SIZE = 32
);
    logic                host_ldr_valid;
    logic [7:0]          host_ldr_byte;
    logic                ldr_host_ready;
    logic                ldr_pm_cslt;
    logic                ldr_pm_wrb;
    logic [PMA_SIZE-1:0] ldr_pm_add;
    logic [PMD_SIZE-1:0] ldr_pm_dt;
    logic                ldr_core_rst;
    logic                ldr_done;
    logic                ldr_err;

    modport master (
        output host_ldr_valid, host_ldr_byte,
        input  ldr_host_ready, ldr_pm_cslt, ldr_pm_wrb, ldr_pm_add, ldr_pm_dt,
        input  ldr_core_rst, ldr_done, ldr_err
    );

    modport slave (
        input  host_ldr_valid, host_ldr_byte,
        output ldr_host_ready, ldr_pm_cslt, ldr_pm_wrb, ldr_pm_add, ldr_pm_dt,
        output ldr_core_rst, ldr_done, ldr_err
    );
endinterface

// File: rtl/pm_loader.sv
// Byte-stream program-memory loader: a header gives the start address and word count.
// Words are written one per WRITE cycle, then an XOR checksum gates release of the core.
module pm_loader #(
    parameter int PMA_SIZE = 16,
    parameter int PMD_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    pm_loader_if.slave  bus
);
    localparam int B = PMD_SIZE / 8;

    localparam logic [2:0] HDR   = 3'd0;
    localparam logic [2:0] DATA  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] CHK   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    logic [2:0]          state;
    logic [1:0]          hdr_cnt;
    logic [7:0]          byte_cnt;
    logic [15:0]         word_cnt;
    logic [7:0]          addr_hi;
    logic [PMA_SIZE-1:0] addr;
    logic [PMD_SIZE-1:0] asm_word;
    logic [7:0]          chk;
    logic [PMA_SIZE-1:0] pm_add_q;
    logic [PMD_SIZE-1:0] pm_dt_q;

    logic                accept;
    logic [PMD_SIZE-1:0] word_next;

    assign bus.ldr_host_ready = !reset && (state == HDR || state == DATA || state == CHK);
    assign accept             = bus.host_ldr_valid && bus.ldr_host_ready;
    // Casting the concatenation keeps the shift legal even for 8-bit words.
    assign word_next          = PMD_SIZE'({asm_word, bus.host_ldr_byte});

    assign bus.ldr_pm_cslt  = (state == WRITE);
    assign bus.ldr_pm_wrb   = (state == WRITE);
    assign bus.ldr_pm_add   = pm_add_q;
    assign bus.ldr_pm_dt    = pm_dt_q;
    assign bus.ldr_done     = (state == DONE);
    assign bus.ldr_err      = (state == ERR);
    assign bus.ldr_core_rst = (state != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HDR;
            hdr_cnt  <= 2'd0;
            byte_cnt <= 8'd0;
            word_cnt <= 16'd0;
            addr_hi  <= 8'd0;
            addr     <= '0;
            asm_word <= '0;
            chk      <= 8'd0;
            pm_add_q <= '0;
            pm_dt_q  <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (accept) begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        case (hdr_cnt)
                            2'd0: addr_hi <= bus.host_ldr_byte;
                            2'd1: addr <= PMA_SIZE'({addr_hi, bus.host_ldr_byte});
                            2'd2: word_cnt[15:8] <= bus.host_ldr_byte;
                            default: begin
                                word_cnt[7:0] <= bus.host_ldr_byte;
                                state <= ({word_cnt[15:8], bus.host_ldr_byte} == 16'd0) ? CHK : DATA;
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (accept) begin
                        chk      <= chk ^ bus.host_ldr_byte;
                        asm_word <= word_next;
                        if (byte_cnt == 8'(B - 1)) begin
                            byte_cnt <= 8'd0;
                            pm_dt_q  <= word_next;
                            pm_add_q <= addr;
                            state    <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                WRITE: begin
                    addr     <= addr + PMA_SIZE'(1);
                    word_cnt <= word_cnt - 16'd1;
                    asm_word <= '0;
                    state    <= (word_cnt == 16'd1) ? CHK : DATA;
                end
                CHK: begin
                    if (accept) begin
                        state <= (bus.host_ldr_byte == chk) ? DONE : ERR;
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule
